seq_mult_param: RTL
===================

SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL provide parameter SIGNED_EN, default 1; when 0, signed_mode is ignored and treated as 0.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a multiply; sampled only while ready=1.
REQ-006 signed_mode  input  1  1 = operands and result are two's complement; 0 = unsigned.
REQ-007 a_in  input  WIDTH  multiplicand, sampled on the accepting edge.
REQ-008 b_in  input  WIDTH  multiplier, sampled on the accepting edge.
REQ-009 ready  output  1  high exactly while the state is IDLE.
REQ-010 done  output  1  one-cycle pulse marking r valid for the new result.
REQ-011 r  output  2*WIDTH  product register; holds its value until the next DONE.

Function
REQ-012 The FSM SHALL have states IDLE, AB0, OP and DONE; any unreachable encoding SHALL return to IDLE.
REQ-013 Accept: in IDLE, start=1 at edge T SHALL capture |a_in|, |b_in|, result sign and mode.
  - |x| is the two's-complement magnitude when signed, else x.
  - Result sign = a_in[MSB] XOR b_in[MSB] when signed, else 0.
REQ-014 At edge T the FSM SHALL go to AB0 if a_in==0 or b_in==0, else to OP; it SHALL clear the accumulator in both cases.
REQ-015 AB0 SHALL last exactly one cycle and then go to DONE, so done is high in cycle T+2 with r=0.
REQ-016 Each OP cycle SHALL perform radix-2 shift-add on the magnitudes:
  - if n[0]=1, acc += a_sh;
  - a_sh shifts left 1 (2*WIDTH bits wide); n shifts right 1.
REQ-017 OP SHALL exit to DONE on the edge where the next value of n is 0 (early termination).
  - OP lasts k = floor(log2|b|)+1 cycles.
  - done is high in cycle T+1+k.
  - Worst case k = WIDTH.
REQ-018 On the OP->DONE edge, r SHALL load the final product: -acc (2*WIDTH-bit two's complement) if the result sign is 1, else acc.
REQ-019 DONE SHALL last exactly one cycle with done=1 and ready=0, then go to IDLE.
REQ-020 done SHALL be 0 in every state other than DONE.
REQ-021 start SHALL be ignored in AB0, OP and DONE.
  - Operand changes during those states SHALL NOT affect the operation in flight.
  - start in the IDLE cycle immediately after DONE SHALL be accepted, so back-to-back operation is allowed.
REQ-022 Magnitude of -2^(WIDTH-1) SHALL be computed as 2^(WIDTH-1) without overflow.
  - The result SHALL be exact for every operand pair, since |product| <= 2^(2*WIDTH-2).
REQ-023 r SHALL change only on the edge entering DONE or on reset.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for a clock edge:
  - force state IDLE;
  - clear accumulator, shift registers and r to 0;
  - drive ready=1 and done=0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse; r SHALL read 0 after reset.
REQ-026 start SHALL NOT be accepted on a clock edge at which rst_n=0.

Verification (WIDTH=8, SIGNED_EN=1, start sampled at edge T)
REQ-027 Unsigned 13 x 11 -> k=4, done high in cycle T+5, r=16'h008F, ready low in T+1..T+5.
REQ-028 Signed -3 (8'hFD) x 5 -> k=3, done in T+4, r=16'hFFF1; signed -128 x -128 (8'h80 x 8'h80) -> k=8, r=16'h4000.
REQ-029 Zero and full-range operands:
  - unsigned 0 x 200 -> AB0 path, done in T+2, r=0;
  - unsigned 255 x 255 -> k=8, done in T+9, r=16'hFE01.
REQ-030 Start/operand changes while busy:
  - start pulsed with a_in/b_in changed during OP of 13 x 11 -> ignored, result still 16'h008F;
  - start held high through DONE -> next multiply accepted in the first IDLE cycle.
REQ-031 rst_n asserted asynchronously (between edges) in the second OP cycle of 255 x 255:
  - ready=1 and r=0 before the next edge;
  - no done pulse;
  - a subsequent 7 x 6 returns 16'h002A.

Source files
------------

// File: rtl/seq_mult_param.sv
// Radix-2 shift-add multiplier with early termination: done in cycle T+1+k (k = bit length of |b|), T+2 for a zero operand.
// Backpressure: ready is high only in IDLE; start is ignored while busy, so the caller holds start until ready.
module seq_mult_param #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] r
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AB0  = 2'd1,
    OP   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;

  logic [PW-1:0]     r_acc;
  logic [PW-1:0]     r_ash;
  logic [WIDTH-1:0]  r_n;
  logic              r_neg;
  logic [PW-1:0]     r_prod;

  logic              w_signed;
  logic [WIDTH-1:0]  w_a_mag;
  logic [WIDTH-1:0]  w_b_mag;
  logic              w_any_zero;
  logic [WIDTH-1:0]  w_n_nxt;
  logic [PW-1:0]     w_acc_nxt;
  logic [PW-1:0]     w_res;

  // Negating -2^(WIDTH-1) in WIDTH bits yields 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign w_signed   = (SIGNED_EN != 0) && signed_mode;
  assign w_a_mag    = (w_signed && a_in[WIDTH-1]) ? (-a_in) : a_in;
  assign w_b_mag    = (w_signed && b_in[WIDTH-1]) ? (-b_in) : b_in;
  assign w_any_zero = (a_in == '0) || (b_in == '0);

  assign w_n_nxt   = r_n >> 1;
  assign w_acc_nxt = r_acc + (r_n[0] ? r_ash : '0);
  assign w_res     = r_neg ? (-w_acc_nxt) : w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    ready       = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_any_zero ? AB0 : OP;
        end
      end
      AB0: begin
        w_state_nxt = DONE;
      end
      OP: begin
        if (w_n_nxt == '0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_ash  <= '0;
      r_n    <= '0;
      r_neg  <= 1'b0;
      r_prod <= '0;
    end else begin
      if (w_accept) begin
        r_acc <= '0;
        r_ash <= {{WIDTH{1'b0}}, w_a_mag};
        r_n   <= w_b_mag;
        r_neg <= w_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
      end else if (r_state == OP) begin
        r_acc <= w_acc_nxt;
        r_ash <= r_ash << 1;
        r_n   <= w_n_nxt;
        if (w_n_nxt == '0) begin
          r_prod <= w_res;
        end
      end else if (r_state == AB0) begin
        r_prod <= '0;
      end
    end
  end

  assign r = r_prod;

  a_done_not_ready: assert property (@(posedge clk) disable iff (!rst_n) done |-> !ready);

endmodule
